mpr121_poller: RTL and testbench



---
 rtl/mpr121_poller_pkg.sv | 59 +++++
 rtl/mpr121_poller_init_rom.sv | 43 ++++
 rtl/mpr121_poller.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_mpr121_poller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpr121_poller_pkg.sv
// ============================================================================
// mpr121_defs : MPR121 register constants, poller state and command flag types
// Rev 1.0
// ============================================================================
`default_nettype none

package mpr121_defs;

    localparam logic [7:0] c_REG_SRST   = 8'h80;
    localparam logic [7:0] c_SRST_VAL   = 8'h63;
    localparam logic [7:0] c_REG_ECR    = 8'h5E;
    localparam logic [7:0] c_REG_TTH0   = 8'h41;
    localparam logic [7:0] c_REG_STATUS = 8'h00;
    localparam logic [7:0] c_ECR_STOP   = 8'h00;
    localparam logic [7:0] c_ECR_RUN    = 8'h0C;

    localparam int c_ROM_DEPTH = 31;
    localparam int c_ROM_AW    = 5;
    localparam int c_TO_W      = 22;

    typedef enum logic [3:0] {
        ST_INIT_CMD  = 4'd0,
        ST_INIT_DATA = 4'd1,
        ST_WAIT      = 4'd2,
        ST_ADDR_CMD  = 4'd3,
        ST_ADDR_DATA = 4'd4,
        ST_RD0_CMD   = 4'd5,
        ST_RD0_DATA  = 4'd6,
        ST_RD1_CMD   = 4'd7,
        ST_RD1_DATA  = 4'd8,
        ST_PUBLISH   = 4'd9,
        ST_RECOVER   = 4'd10
    } poller_state_t;

    typedef struct packed {
        logic start;
        logic read;
        logic write;
        logic write_multiple;
        logic stop;
    } cmd_flags_t;

    // Command flags presented while the FSM sits in each command state.
    function automatic cmd_flags_t cmd_flags_for(input poller_state_t s);
        cmd_flags_t f;
        f = '0;
        case (s)
            ST_INIT_CMD: begin f.start = 1'b1; f.write_multiple = 1'b1; f.stop = 1'b1; end
            ST_ADDR_CMD: begin f.start = 1'b1; f.write = 1'b1; end
            ST_RD0_CMD:  begin f.start = 1'b1; f.read = 1'b1; end
            ST_RD1_CMD:  begin f.read = 1'b1; f.stop = 1'b1; end
            default:     f = '0;
        endcase
        return f;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mpr121_poller_init_rom.sv
// ============================================================================
// mpr121_init_rom : initialisation byte stream with transaction/sequence marks
// Rev 1.0
// ============================================================================
`default_nettype none

module mpr121_init_rom
    import mpr121_defs::*;
#(
    parameter logic [7:0] TOUCH_TH   = 8'h0F,
    parameter logic [7:0] RELEASE_TH = 8'h0A
) (
    input  logic [c_ROM_AW-1:0] i_idx,
    output logic [7:0]          o_byte,
    output logic                o_last_txn,
    output logic                o_last_seq
);

    always_comb begin
        o_byte     = 8'h00;
        o_last_txn = 1'b0;
        o_last_seq = 1'b0;
        case (i_idx)
            5'd0:  o_byte = c_REG_SRST;
            5'd1:  begin o_byte = c_SRST_VAL; o_last_txn = 1'b1; end
            5'd2:  o_byte = c_REG_ECR;
            5'd3:  begin o_byte = c_ECR_STOP; o_last_txn = 1'b1; end
            5'd4:  o_byte = c_REG_TTH0;
            5'd29: o_byte = c_REG_ECR;
            5'd30: begin o_byte = c_ECR_RUN; o_last_txn = 1'b1; o_last_seq = 1'b1; end
            default: begin
                // Indices 5..28 alternate touch/release threshold per electrode.
                if (i_idx >= 5'd5 && i_idx <= 5'd28) begin
                    o_byte     = i_idx[0] ? TOUCH_TH : RELEASE_TH;
                    o_last_txn = (i_idx == 5'd28);
                end
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mpr121_poller.sv
// ============================================================================
// mpr121_poller : MPR121 init sequencer and periodic touch-status poller
// Rev 1.0
// ============================================================================
`default_nettype none

module mpr121_poller
    import mpr121_defs::*;
#(
    parameter logic [6:0] I2C_ADDR      = 7'h5A,
    parameter logic [7:0] TOUCH_TH      = 8'h0F,
    parameter logic [7:0] RELEASE_TH    = 8'h0A,
    parameter int         POLL_INTERVAL = 27000,
    parameter int         RX_TIMEOUT    = 2700000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_multiple,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    output logic        rx_tready,
    output logic [11:0] touch_status,
    output logic [11:0] pressed,
    output logic [11:0] released,
    output logic        status_valid,
    output logic        init_done,
    output logic        error
);

    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(RX_TIMEOUT);
    localparam logic [31:0]       c_WAIT_END = 32'(POLL_INTERVAL - 1);

    poller_state_t       r_state;
    logic [c_ROM_AW-1:0] r_rom_idx;
    cmd_flags_t          r_flags;
    logic                r_cmd_valid;
    logic [7:0]          r_tx_tdata;
    logic                r_tx_tvalid;
    logic                r_tx_tlast;
    logic                r_tx_seq_last;
    logic                r_rx_tready;
    logic [7:0]          r_byte0;
    logic [11:0]         r_touch;
    logic [11:0]         r_pressed;
    logic [11:0]         r_released;
    logic                r_status_valid;
    logic                r_init_done;
    logic                r_error;
    logic [31:0]         r_wait_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic [7:0]  w_rom_byte;
    logic        w_rom_last_txn;
    logic        w_rom_last_seq;
    logic        w_waiting;
    logic        w_hs;
    logic        w_timeout;
    logic [11:0] w_new;
    logic        w_unused;

    mpr121_init_rom #(
        .TOUCH_TH   (TOUCH_TH),
        .RELEASE_TH (RELEASE_TH)
    ) u_rom (
        .i_idx      (r_rom_idx),
        .o_byte     (w_rom_byte),
        .o_last_txn (w_rom_last_txn),
        .o_last_seq (w_rom_last_seq)
    );

    assign w_new    = {rx_tdata[3:0], r_byte0};
    assign w_unused = ^{rx_tlast, rx_tdata[6:4]};

    always_comb begin
        w_waiting = 1'b0;
        w_hs      = 1'b0;
        case (r_state)
            ST_INIT_CMD, ST_ADDR_CMD, ST_RD0_CMD, ST_RD1_CMD: begin
                w_waiting = 1'b1;
                w_hs      = r_cmd_valid & cmd_ready;
            end
            ST_INIT_DATA, ST_ADDR_DATA: begin
                w_waiting = 1'b1;
                w_hs      = r_tx_tvalid & tx_tready;
            end
            ST_RD0_DATA, ST_RD1_DATA: begin
                w_waiting = 1'b1;
                w_hs      = r_rx_tready & rx_tvalid;
            end
            default: begin
                w_waiting = 1'b0;
                w_hs      = 1'b0;
            end
        endcase
    end

    assign w_timeout = w_waiting & ~w_hs & (r_to_cnt >= c_TO_LIMIT);

    // Every state change out of a waiting state is a handshake, so clearing on
    // handshake (or when not waiting) restarts the count on each new state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (w_hs || !w_waiting) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != {c_TO_W{1'b1}}) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_INIT_CMD;
            r_rom_idx      <= '0;
            r_flags        <= '0;
            r_cmd_valid    <= 1'b0;
            r_tx_tdata     <= 8'h00;
            r_tx_tvalid    <= 1'b0;
            r_tx_tlast     <= 1'b0;
            r_tx_seq_last  <= 1'b0;
            r_rx_tready    <= 1'b0;
            r_byte0        <= 8'h00;
            r_touch        <= '0;
            r_pressed      <= '0;
            r_released     <= '0;
            r_status_valid <= 1'b0;
            r_init_done    <= 1'b0;
            r_error        <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            r_status_valid <= 1'b0;
            r_pressed      <= '0;
            r_released     <= '0;
            if (r_state != ST_WAIT) begin
                r_wait_cnt <= '0;
            end

            if (w_timeout) begin
                r_error     <= 1'b1;
                r_init_done <= 1'b0;
                r_cmd_valid <= 1'b0;
                r_tx_tvalid <= 1'b0;
                r_tx_tlast  <= 1'b0;
                r_rx_tready <= 1'b0;
                r_state     <= ST_RECOVER;
            end else begin
                case (r_state)
                    ST_INIT_CMD, ST_ADDR_CMD, ST_RD0_CMD, ST_RD1_CMD: begin
                        // Command is raised on the first cycle in the state, then held.
                        if (!r_cmd_valid) begin
                            r_cmd_valid <= 1'b1;
                            r_flags     <= cmd_flags_for(r_state);
                        end else if (cmd_ready) begin
                            r_cmd_valid <= 1'b0;
                            r_flags     <= '0;
                            case (r_state)
                                ST_INIT_CMD: begin
                                    r_tx_tvalid   <= 1'b1;
                                    r_tx_tdata    <= w_rom_byte;
                                    r_tx_tlast    <= w_rom_last_txn;
                                    r_tx_seq_last <= w_rom_last_seq;
                                    r_rom_idx     <= r_rom_idx + 1'b1;
                                    r_state       <= ST_INIT_DATA;
                                end
                                ST_ADDR_CMD: begin
                                    r_tx_tvalid   <= 1'b1;
                                    r_tx_tdata    <= c_REG_STATUS;
                                    r_tx_tlast    <= 1'b1;
                                    r_tx_seq_last <= 1'b0;
                                    r_state       <= ST_ADDR_DATA;
                                end
                                ST_RD0_CMD: begin
                                    r_rx_tready <= 1'b1;
                                    r_state     <= ST_RD0_DATA;
                                end
                                default: begin
                                    r_rx_tready <= 1'b1;
                                    r_state     <= ST_RD1_DATA;
                                end
                            endcase
                        end
                    end
                    ST_INIT_DATA: begin
                        if (tx_tready) begin
                            if (r_tx_seq_last) begin
                                r_tx_tvalid   <= 1'b0;
                                r_tx_tlast    <= 1'b0;
                                r_tx_seq_last <= 1'b0;
                                r_init_done   <= 1'b1;
                                r_state       <= ST_WAIT;
                            end else if (r_tx_tlast) begin
                                r_tx_tvalid <= 1'b0;
                                r_tx_tlast  <= 1'b0;
                                r_state     <= ST_INIT_CMD;
                            end else begin
                                r_tx_tdata    <= w_rom_byte;
                                r_tx_tlast    <= w_rom_last_txn;
                                r_tx_seq_last <= w_rom_last_seq;
                                r_rom_idx     <= r_rom_idx + 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (r_wait_cnt >= c_WAIT_END) begin
                            if (enable) begin
                                r_state <= ST_ADDR_CMD;
                            end
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 32'd1;
                        end
                    end
                    ST_ADDR_DATA: begin
                        if (tx_tready) begin
                            r_tx_tvalid <= 1'b0;
                            r_tx_tlast  <= 1'b0;
                            r_state     <= ST_RD0_CMD;
                        end
                    end
                    ST_RD0_DATA: begin
                        if (rx_tvalid) begin
                            r_byte0     <= rx_tdata;
                            r_rx_tready <= 1'b0;
                            r_state     <= ST_RD1_CMD;
                        end
                    end
                    ST_RD1_DATA: begin
                        if (rx_tvalid) begin
                            r_rx_tready <= 1'b0;
                            // Over-current: drop this sample and re-run init from T0.
                            if (rx_tdata[7]) begin
                                r_error     <= 1'b1;
                                r_init_done <= 1'b0;
                                r_rom_idx   <= '0;
                                r_state     <= ST_INIT_CMD;
                            end else begin
                                r_touch        <= w_new;
                                r_pressed      <= w_new & ~r_touch;
                                r_released     <= r_touch & ~w_new;
                                r_status_valid <= 1'b1;
                                r_state        <= ST_PUBLISH;
                            end
                        end
                    end
                    ST_PUBLISH: begin
                        r_state <= ST_WAIT;
                    end
                    default: begin
                        r_rom_idx <= '0;
                        r_state   <= ST_INIT_CMD;
                    end
                endcase
            end
        end
    end

    assign cmd_address        = I2C_ADDR;
    assign cmd_start          = r_flags.start;
    assign cmd_read           = r_flags.read;
    assign cmd_write          = r_flags.write;
    assign cmd_write_multiple = r_flags.write_multiple;
    assign cmd_stop           = r_flags.stop;
    assign cmd_valid          = r_cmd_valid;
    assign tx_tdata           = r_tx_tdata;
    assign tx_tvalid          = r_tx_tvalid;
    assign tx_tlast           = r_tx_tlast;
    assign rx_tready          = r_rx_tready;
    assign touch_status       = r_touch;
    assign pressed            = r_pressed;
    assign released           = r_released;
    assign status_valid       = r_status_valid;
    assign init_done          = r_init_done;
    assign error              = r_error;

endmodule

`default_nettype wire

// File: tb/tb_mpr121_poller.sv
// ============================================================================
// tb_mpr121_poller : directed bench with an I2C-master stand-in and scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mpr121_poller;

    localparam int         c_POLL = 20;
    localparam int         c_TO   = 200;
    localparam logic [4:0] c_F_INIT = 5'b10011;   // {start,read,write,wm,stop}
    localparam logic [4:0] c_F_ADDR = 5'b10100;
    localparam logic [4:0] c_F_RD0  = 5'b11000;
    localparam logic [4:0] c_F_RD1  = 5'b01001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid, tx_tlast;
    logic        tx_tready;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tlast;
    logic        rx_tready;
    logic [11:0] touch_status, pressed, released;
    logic        status_valid, init_done, error;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sv_cnt   = 0;
    logic        rand_tx  = 1'b0;
    logic        rx_mute  = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  hold_data = 8'h00;
    logic [4:0]  cmd_log[$];
    logic [8:0]  tx_log[$];
    logic [8:0]  exp_tx[$];
    logic [7:0]  rx_q[$];

    always #5 clk = ~clk;

    mpr121_poller #(
        .POLL_INTERVAL (c_POLL),
        .RX_TIMEOUT    (c_TO)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .cmd_address        (cmd_address),
        .cmd_start          (cmd_start),
        .cmd_read           (cmd_read),
        .cmd_write          (cmd_write),
        .cmd_write_multiple (cmd_write_multiple),
        .cmd_stop           (cmd_stop),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .tx_tdata           (tx_tdata),
        .tx_tvalid          (tx_tvalid),
        .tx_tlast           (tx_tlast),
        .tx_tready          (tx_tready),
        .rx_tdata           (rx_tdata),
        .rx_tvalid          (rx_tvalid),
        .rx_tlast           (rx_tlast),
        .rx_tready          (rx_tready),
        .touch_status       (touch_status),
        .pressed            (pressed),
        .released           (released),
        .status_valid       (status_valid),
        .init_done          (init_done),
        .error              (error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        cmd_log.delete();
        tx_log.delete();
    endtask

    task automatic compare_init();
        check_val("init_cmd_count", cmd_log.size(), 4);
        for (int i = 0; i < cmd_log.size() && i < 4; i++)
            check_val("init_cmd_flags", cmd_log[i], c_F_INIT);
        check_val("init_tx_count", tx_log.size(), exp_tx.size());
        for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            check_val($sformatf("init_tx_%0d", i), tx_log[i], exp_tx[i]);
    endtask

    // I2C master stand-in: drives ready/rx at negedge and logs the handshakes
    // that the following posedge will complete.
    initial begin
        cmd_ready = 1'b1;
        tx_tready = 1'b1;
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        rx_tlast  = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
                rx_tvalid = 1'b0;
            end else begin
                if (hold_prev) begin
                    check_val("tx_hold_valid", tx_tvalid, 1);
                    check_val("tx_hold_data", tx_tdata, hold_data);
                end
                tx_tready = rand_tx ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rx_tready && !rx_mute && rx_q.size() > 0) begin
                    rx_tvalid = 1'b1;
                    rx_tdata  = rx_q[0];
                end else begin
                    rx_tvalid = 1'b0;
                end
                if (cmd_valid && cmd_ready) begin
                    cmd_log.push_back({cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop});
                    check_val("cmd_address", cmd_address, 7'h5A);
                end
                if (tx_tvalid && tx_tready)
                    tx_log.push_back({tx_tlast, tx_tdata});
                if (rx_tvalid && rx_tready)
                    void'(rx_q.pop_front());
                hold_prev = tx_tvalid && !tx_tready;
                hold_data = tx_tdata;
                if (status_valid)
                    sv_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int sv0;

        exp_tx = {9'h080, 9'h163, 9'h05E, 9'h100, 9'h041};
        for (int i = 0; i < 12; i++) begin
            exp_tx.push_back({1'b0, 8'h0F});
            exp_tx.push_back({(i == 11), 8'h0A});
        end
        exp_tx.push_back(9'h05E);
        exp_tx.push_back(9'h10C);

        // Reset values
        cycles(3);
        check_val("rst_cmd_valid", cmd_valid, 0);
        check_val("rst_tx_tvalid", tx_tvalid, 0);
        check_val("rst_rx_tready", rx_tready, 0);
        check_val("rst_flags", {cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop}, 0);
        check_val("rst_outputs", {touch_status, pressed, released, status_valid, init_done, error}, 0);
        check_val("rst_address", cmd_address, 7'h5A);

        // Initialisation with ready held high
        clear_logs();
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 500) begin cycles(1); n++; end
        check_val("init_done", init_done, 1);
        check_val("init_error", error, 0);
        compare_init();

        // Two polls: 0x05/0x08 then 0x01/0x08
        rx_q = {8'h05, 8'h08, 8'h01, 8'h08};
        clear_logs();
        enable = 1'b1;
        n = 0;
        while (!status_valid && n < 500) begin cycles(1); n++; end
        check_val("p1_status_valid", status_valid, 1);
        check_val("p1_touch", touch_status, 12'h805);
        check_val("p1_pressed", pressed, 12'h805);
        check_val("p1_released", released, 12'h000);
        cycles(1);
        check_val("p1_pulse_end", {status_valid, pressed, released}, 0);
        check_val("p1_touch_hold", touch_status, 12'h805);
        check_val("p1_cmd_count", cmd_log.size(), 3);
        if (cmd_log.size() == 3) begin
            check_val("p1_cmd_addr", cmd_log[0], c_F_ADDR);
            check_val("p1_cmd_rd0", cmd_log[1], c_F_RD0);
            check_val("p1_cmd_rd1", cmd_log[2], c_F_RD1);
        end
        check_val("p1_tx_count", tx_log.size(), 1);
        if (tx_log.size() == 1)
            check_val("p1_tx_reg", tx_log[0], 9'h100);
        n = 0;
        while (!status_valid && n < 500) begin cycles(1); n++; end
        enable = 1'b0;
        check_val("p2_status_valid", status_valid, 1);
        check_val("p2_touch", touch_status, 12'h801);
        check_val("p2_pressed", pressed, 12'h000);
        check_val("p2_released", released, 12'h004);

        // Enable dropped while the chip has not yet returned byte0
        rx_mute = 1'b1;
        rx_q = {8'h03, 8'h00};
        cycles(2);
        enable = 1'b1;
        n = 0;
        while (!rx_tready && n < 500) begin cycles(1); n++; end
        check_val("en_rd0_reached", rx_tready, 1);
        enable  = 1'b0;
        rx_mute = 1'b0;
        n = 0;
        while (!status_valid && n < 500) begin cycles(1); n++; end
        check_val("en_status_valid", status_valid, 1);
        check_val("en_touch", touch_status, 12'h003);
        check_val("en_pressed", pressed, 12'h002);
        check_val("en_released", released, 12'h800);
        clear_logs();
        cycles(4 * c_POLL);
        check_val("en_no_new_poll", cmd_log.size(), 0);
        enable = 1'b1;
        n = 0;
        while (cmd_log.size() == 0 && n < 3 * c_POLL) begin cycles(1); n++; end
        enable = 1'b0;
        check_val("en_resume_count", cmd_log.size() > 0, 1);
        if (cmd_log.size() > 0)
            check_val("en_resume_cmd", cmd_log[0], c_F_ADDR);

        // Async reset mid-transfer, then init under random tx_tready
        rst = 1'b1;
        cycles(2);
        rand_tx = 1'b1;
        rst = 1'b0;
        n = 0;
        while (!tx_tvalid && n < 100) begin cycles(1); n++; end
        check_val("ar_tx_seen", tx_tvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("ar_valids_drop", {cmd_valid, tx_tvalid, rx_tready}, 0);
        check_val("ar_touch_clr", touch_status, 0);
        cycles(2);
        clear_logs();
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 1000) begin cycles(1); n++; end
        rand_tx = 1'b0;
        check_val("rnd_init_done", init_done, 1);
        compare_init();

        // Slave never returns byte1
        rx_q = {8'h05};
        enable = 1'b1;
        n = 0;
        while (rx_q.size() != 0 && n < 500) begin cycles(1); n++; end
        check_val("to_byte0_taken", rx_q.size(), 0);
        n = 0;
        while (!error && n < 1000) begin cycles(1); n++; end
        check_val("to_error", error, 1);
        check_val("to_init_done", init_done, 0);
        check_val("to_valids", {cmd_valid, tx_tvalid, rx_tready}, 0);
        check_val("to_min_wait", n >= c_TO, 1);
        check_val("to_max_wait", n <= c_TO + 10, 1);
        clear_logs();
        n = 0;
        while (tx_log.size() < 2 && n < 50) begin cycles(1); n++; end
        enable = 1'b0;
        check_val("to_reinit_cmds", cmd_log.size() > 0, 1);
        if (cmd_log.size() > 0)
            check_val("to_reinit_flags", cmd_log[0], c_F_INIT);
        check_val("to_reinit_tx", tx_log.size(), 2);
        if (tx_log.size() >= 2)
            check_val("to_reinit_t0", {tx_log[0], tx_log[1]}, {9'h080, 9'h163});

        // Over-current in byte1
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        n = 0;
        while (!init_done && n < 500) begin cycles(1); n++; end
        check_val("oc_pre_init", {init_done, error}, 2'b10);
        rx_q = {8'h00, 8'h80};
        sv0 = sv_cnt;
        enable = 1'b1;
        n = 0;
        while (!error && n < 500) begin cycles(1); n++; end
        enable = 1'b0;
        check_val("oc_error", error, 1);
        check_val("oc_init_cleared", init_done, 0);
        check_val("oc_no_pulse", status_valid, 0);
        clear_logs();
        n = 0;
        while (!init_done && n < 500) begin cycles(1); n++; end
        check_val("oc_reinit_done", init_done, 1);
        check_val("oc_no_publish", sv_cnt, sv0);
        check_val("oc_touch_kept", touch_status, 12'h000);
        compare_init();
        check_val("oc_error_sticky", error, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
